move_cmd_encoder: RTL and testbench
===================================

Name: move_cmd_encoder

Overview:
- Generates the stream of 4-bit move commands that the position adder datapath consumes.
- Given a latched current (x,y) and target (x,y) on a 16x16 grid, emits a minimal sequence of bounded single-axis steps over a valid/ready handshake.
- Tracks its own running position, so the adder's 5-bit results never need feeding back.
- Sits between the path/target controller and the position adder stage.

Parameters:
- MAX_STEP, 3, largest magnitude per command; legal range 1..3.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  one-cycle request; sampled only in IDLE.
- cur_x  input  4  starting x, latched on accepted start.
- cur_y  input  4  starting y, latched on accepted start.
- tgt_x  input  4  target x, latched on accepted start.
- tgt_y  input  4  target y, latched on accepted start.
- cmd_out  output  4  move command: [3:2] magnitude, [1] axis (0=x, 1=y), [0] sign (1=subtract).
- cmd_valid  output  1  cmd_out holds a command.
- cmd_ready  input  1  consumer accepts cmd_out when cmd_valid is also high.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse when target is reached.
- cmd_count  output  5  commands accepted in the current or last run.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE; cmd_out=0; cmd_valid=0; busy=0; done=0; cmd_count=0; internal pos/tgt registers=0.
- IDLE:
  - start=1 latches cur_x/cur_y into pos_x/pos_y and tgt_x/tgt_y into tgt registers.
  - Clears cmd_count and sets busy=1. Next state is X_STEP.
- X_STEP:
  - dx = tgt_x - pos_x, computed as 5-bit two's complement.
  - If dx=0, go to Y_STEP in the same cycle's next-state logic; no command is emitted.
  - Otherwise present cmd_valid=1 with magnitude = min(|dx|, MAX_STEP), axis=0, sign = (dx<0).
- Y_STEP: same as X_STEP using dy and axis=1. If dy=0, go to DONE.
- Command registration: cmd_out/cmd_valid are registered. The first command appears 1 cycle after the state enters the step state, giving 2 cycles of start-to-first-valid latency.
- Handshake:
  - While cmd_valid=1 and cmd_ready=0, cmd_out holds stable; no change is allowed.
  - On cmd_valid & cmd_ready, pos on the current axis is updated by ±magnitude and cmd_count increments.
  - The next command, or deassertion of cmd_valid, is registered on the following edge.
  - Back-to-back accepts (one per cycle) are supported; the next command is computed from the updated pos.
- Magnitude 0 is never emitted.
- cmd_count saturates at 31; the worst case is 2*ceil(15/1)=30.
- DONE: busy=0, done=1 for exactly one cycle, then return to IDLE. cmd_count holds until the next start.
- Zero-distance run (cur==tgt): no commands, and done pulses 2 cycles after start.
- start while busy is ignored. Target inputs are ignored after latching.
- Internal pos never leaves 0..15, because magnitude is bounded by |d|. No wrap-around occurs.
- rst mid-run: everything returns to reset values immediately. A pending command is dropped and cmd_valid falls asynchronously.

Optional Feature:
- Macro: MOVE_AXIS_INTERLEAVE_EN.
- Defined: after each accepted command the encoder switches axis if the other axis still has nonzero distance. This alternates x, y, x, y and finishes the remaining axis alone; x goes first.
- Undefined: all x commands complete before any y command, as described above.
- cmd_count, handshake rules and done timing are identical in both builds.

Test Plan:
- Reset, then start with cur=(2,3), tgt=(9,3), cmd_ready=1 -> commands 0xC (+3 x), 0xC, 0x4 (+1 x); done pulse; cmd_count=3; no y commands.
- cur=(15,15), tgt=(0,0), MAX_STEP=3 -> five 0xD (-3 x), then five 0xF (-3 y); cmd_count=10; pos never underflows.
- cur=tgt=(7,7) -> cmd_valid never rises; done high exactly 2 cycles after start; cmd_count=0.
- cur=(0,0), tgt=(5,0), cmd_ready low for 4 cycles on the first command -> cmd_out=0xC held stable, cmd_count stays 0 until ready; then 0xC, 0x8.
- rst asserted while second command pending -> cmd_valid, busy and cmd_count drop to 0 immediately; a fresh start afterwards runs correctly. A start pulsed during busy produces no effect.
- With MOVE_AXIS_INTERLEAVE_EN, cur=(0,0), tgt=(6,2) -> 0xC, 0xA (+2 y), 0xC; done; cmd_count=3.

Source files
------------

// File: rtl/move_cmd_encoder.sv
// move_cmd_encoder: turns a latched (cur -> tgt) move on a 16x16 grid into a
// stream of bounded single-axis 4-bit commands over a valid/ready handshake.
// Command format: [3:2] magnitude, [1] axis (0=x, 1=y), [0] sign (1=subtract).
// Build option: define MOVE_AXIS_INTERLEAVE_EN to alternate x/y commands
// (x first) instead of finishing x before starting y.
module move_cmd_encoder #(
  parameter int unsigned MAX_STEP = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] cur_x,
  input  logic [3:0] cur_y,
  input  logic [3:0] tgt_x,
  input  logic [3:0] tgt_y,
  output logic [3:0] cmd_out,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       busy,
  output logic       done,
  output logic [4:0] cmd_count
);

  typedef enum logic [1:0] {IDLE, X_STEP, Y_STEP, DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] pos_x, pos_y, tgt_xr, tgt_yr;
  logic [3:0] pos_x_nxt, pos_y_nxt, tgt_xr_nxt, tgt_yr_nxt;
  logic [3:0] cmd_out_nxt;
  logic       cmd_valid_nxt, busy_nxt, done_nxt;
  logic [4:0] cmd_count_nxt;

  // Build one command that moves p toward t by at most MAX_STEP.
  function automatic logic [3:0] make_cmd(input logic [3:0] p,
                                          input logic [3:0] t,
                                          input logic       axis);
    logic [4:0] d, a;
    logic       neg;
    logic [1:0] m;
    d   = {1'b0, t} - {1'b0, p};
    neg = d[4];
    a   = neg ? (5'd0 - d) : d;
    m   = (a > 5'(MAX_STEP)) ? 2'(MAX_STEP) : a[1:0];
    return {m, axis, neg};
  endfunction

  // Apply an accepted command's magnitude/sign to one coordinate.
  function automatic logic [3:0] apply_cmd(input logic [3:0] p,
                                           input logic [3:0] c);
    return c[0] ? (p - {2'b00, c[3:2]}) : (p + {2'b00, c[3:2]});
  endfunction

  // Next-state and next-register logic for the whole encoder.
  always_comb begin
    state_nxt     = state;
    pos_x_nxt     = pos_x;
    pos_y_nxt     = pos_y;
    tgt_xr_nxt    = tgt_xr;
    tgt_yr_nxt    = tgt_yr;
    cmd_out_nxt   = cmd_out;
    cmd_valid_nxt = cmd_valid;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    cmd_count_nxt = cmd_count;

    case (state)
      IDLE: begin
        if (start) begin
          pos_x_nxt     = cur_x;
          pos_y_nxt     = cur_y;
          tgt_xr_nxt    = tgt_x;
          tgt_yr_nxt    = tgt_y;
          cmd_count_nxt = '0;
          cmd_valid_nxt = 1'b0;
          busy_nxt      = 1'b1;
          state_nxt     = X_STEP;
        end
      end

      X_STEP, Y_STEP: begin
        if (!cmd_valid) begin
          // Entry into a step state: emit the first command, or skip the axis.
          if (state == X_STEP) begin
            if (pos_x == tgt_xr) state_nxt = Y_STEP;
            else begin
              cmd_out_nxt   = make_cmd(pos_x, tgt_xr, 1'b0);
              cmd_valid_nxt = 1'b1;
            end
          end else begin
            if (pos_y == tgt_yr) begin
              state_nxt = DONE;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end else begin
              cmd_out_nxt   = make_cmd(pos_y, tgt_yr, 1'b1);
              cmd_valid_nxt = 1'b1;
            end
          end
        end else if (cmd_ready) begin
          cmd_count_nxt = (cmd_count == 5'd31) ? 5'd31 : cmd_count + 5'd1;
          if (cmd_out[1]) pos_y_nxt = apply_cmd(pos_y, cmd_out);
          else            pos_x_nxt = apply_cmd(pos_x, cmd_out);
          // Finishing the last command drops valid and parks in Y_STEP so the
          // following edge sees zero distance and enters DONE; this keeps done
          // timing identical in both builds.
          cmd_valid_nxt = 1'b0;
`ifdef MOVE_AXIS_INTERLEAVE_EN
          if (!cmd_out[1]) begin
            if (pos_y_nxt != tgt_yr) begin
              cmd_out_nxt   = make_cmd(pos_y_nxt, tgt_yr, 1'b1);
              cmd_valid_nxt = 1'b1;
              state_nxt     = Y_STEP;
            end else if (pos_x_nxt != tgt_xr) begin
              cmd_out_nxt   = make_cmd(pos_x_nxt, tgt_xr, 1'b0);
              cmd_valid_nxt = 1'b1;
            end else state_nxt = Y_STEP;
          end else begin
            if (pos_x_nxt != tgt_xr) begin
              cmd_out_nxt   = make_cmd(pos_x_nxt, tgt_xr, 1'b0);
              cmd_valid_nxt = 1'b1;
              state_nxt     = X_STEP;
            end else if (pos_y_nxt != tgt_yr) begin
              cmd_out_nxt   = make_cmd(pos_y_nxt, tgt_yr, 1'b1);
              cmd_valid_nxt = 1'b1;
            end else state_nxt = Y_STEP;
          end
`else
          if (!cmd_out[1]) begin
            if (pos_x_nxt != tgt_xr) begin
              cmd_out_nxt   = make_cmd(pos_x_nxt, tgt_xr, 1'b0);
              cmd_valid_nxt = 1'b1;
            end else state_nxt = Y_STEP;
          end else begin
            if (pos_y_nxt != tgt_yr) begin
              cmd_out_nxt   = make_cmd(pos_y_nxt, tgt_yr, 1'b1);
              cmd_valid_nxt = 1'b1;
            end
          end
`endif
        end
      end

      DONE: state_nxt = IDLE;

      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; reset drops any pending command at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pos_x     <= '0;
      pos_y     <= '0;
      tgt_xr    <= '0;
      tgt_yr    <= '0;
      cmd_out   <= '0;
      cmd_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_count <= '0;
    end else begin
      state     <= state_nxt;
      pos_x     <= pos_x_nxt;
      pos_y     <= pos_y_nxt;
      tgt_xr    <= tgt_xr_nxt;
      tgt_yr    <= tgt_yr_nxt;
      cmd_out   <= cmd_out_nxt;
      cmd_valid <= cmd_valid_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      cmd_count <= cmd_count_nxt;
    end
  end

endmodule

// File: tb/tb_move_cmd_encoder.sv
// Directed bench for move_cmd_encoder; expected command streams follow the
// build option MOVE_AXIS_INTERLEAVE_EN when it is defined.
module tb_move_cmd_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] cur_x = '0, cur_y = '0, tgt_x = '0, tgt_y = '0;
  logic [3:0] cmd_out;
  logic       cmd_valid;
  logic       cmd_ready = 1'b0;
  logic       busy, done;
  logic [4:0] cmd_count;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  move_cmd_encoder #(.MAX_STEP(3)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cur_x(cur_x), .cur_y(cur_y), .tgt_x(tgt_x), .tgt_y(tgt_y),
    .cmd_out(cmd_out), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .busy(busy), .done(done), .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a valid command, check it, and let it be accepted.
  task automatic get_cmd(input string tag, input logic [3:0] exp);
    int n = 0;
    while (cmd_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check({tag, "_valid"}, cmd_valid, 1);
    check({tag, "_cmd"}, cmd_out, exp);
    step();
  endtask

  task automatic wait_done(input string tag, input logic [4:0] exp_count);
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid_at_done"}, cmd_valid, 0);
    check({tag, "_count"}, cmd_count, exp_count);
    step();
    check({tag, "_done_1cyc"}, done, 0);
  endtask

  task automatic go(input logic [3:0] cx, input logic [3:0] cy,
                    input logic [3:0] tx, input logic [3:0] ty);
    cur_x = cx; cur_y = cy; tgt_x = tx; tgt_y = ty;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_valid", cmd_valid, 0);
    check("rst_cmd", cmd_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", cmd_count, 0);
    step(); step();
    rst = 1'b0;
    step();

    // T1: +x only, with a start pulse and target change while busy
    cmd_ready = 1'b1;
    go(4'd2, 4'd3, 4'd9, 4'd3);
    check("t1_busy", busy, 1);
    check("t1_valid_lat1", cmd_valid, 0);
    step();
    check("t1_valid_lat2", cmd_valid, 1);
    get_cmd("t1_c0", 4'hC);
    start = 1'b1; cur_x = 4'd0; tgt_x = 4'd0; tgt_y = 4'd15;
    get_cmd("t1_c1", 4'hC);
    start = 1'b0;
    get_cmd("t1_c2", 4'h4);
    wait_done("t1", 5'd3);

    // T2: full diagonal down to origin
    go(4'd15, 4'd15, 4'd0, 4'd0);
`ifdef MOVE_AXIS_INTERLEAVE_EN
    for (int i = 0; i < 5; i++) begin
      get_cmd("t2_x", 4'hD);
      get_cmd("t2_y", 4'hF);
    end
`else
    for (int i = 0; i < 5; i++) get_cmd("t2_x", 4'hD);
    for (int i = 0; i < 5; i++) get_cmd("t2_y", 4'hF);
`endif
    wait_done("t2", 5'd10);

    // T3: zero distance, done exactly two edges after start
    go(4'd7, 4'd7, 4'd7, 4'd7);
    check("t3_busy", busy, 1);
    check("t3_done_e0", done, 0);
    step();
    check("t3_valid_e1", cmd_valid, 0);
    check("t3_done_e1", done, 0);
    step();
    check("t3_valid_e2", cmd_valid, 0);
    check("t3_done_e2", done, 1);
    check("t3_count", cmd_count, 0);
    step();
    check("t3_done_e3", done, 0);

    // T4: backpressure holds the first command stable
    cmd_ready = 1'b0;
    go(4'd0, 4'd0, 4'd5, 4'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      check("t4_hold_valid", cmd_valid, 1);
      check("t4_hold_cmd", cmd_out, 4'hC);
      check("t4_hold_count", cmd_count, 0);
      step();
    end
    cmd_ready = 1'b1;
    get_cmd("t4_c0", 4'hC);
    get_cmd("t4_c1", 4'h8);
    wait_done("t4", 5'd2);

    // T5: asynchronous reset with a pending command, then a clean rerun
    go(4'd2, 4'd3, 4'd9, 4'd3);
    get_cmd("t5_c0", 4'hC);
    cmd_ready = 1'b0;
    check("t5_pend_valid", cmd_valid, 1);
    check("t5_pend_count", cmd_count, 1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_valid", cmd_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_count", cmd_count, 0);
    check("t5_rst_cmd", cmd_out, 0);
    #2 rst = 1'b0;
    step();
    cmd_ready = 1'b1;
    go(4'd0, 4'd0, 4'd5, 4'd0);
    get_cmd("t5_r0", 4'hC);
    get_cmd("t5_r1", 4'h8);
    wait_done("t5", 5'd2);

    // T6: mixed axes
    go(4'd0, 4'd0, 4'd6, 4'd2);
`ifdef MOVE_AXIS_INTERLEAVE_EN
    get_cmd("t6_c0", 4'hC);
    get_cmd("t6_c1", 4'hA);
    get_cmd("t6_c2", 4'hC);
`else
    get_cmd("t6_c0", 4'hC);
    get_cmd("t6_c1", 4'hC);
    get_cmd("t6_c2", 4'hA);
`endif
    wait_done("t6", 5'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
